// File: rtl/sort_pkg.sv
// Shared definitions for the sorting engine: sizes, sequencer states and
// the field layout of a tagged sorter entry.
package sort_pkg;

    localparam int N_ENTRIES = 32;
    localparam int IDX_W     = 5;
    localparam int KEY_W     = 24;
    localparam int ENTRY_W   = IDX_W + KEY_W;   // 29

    // Entry layout: {idx[28:24], cls[23:22], a[21:16], b[15:8], c[7:0]}
    localparam int IDX_LSB = 24;
    localparam int CLS_LSB = 22;
    localparam int A_LSB   = 16;
    localparam int B_LSB   = 8;
    localparam int C_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } sort_state_t;

    // Tag a key with its arrival index to form a sorter entry.
    function automatic logic [ENTRY_W-1:0] make_entry(input logic [IDX_W-1:0] idx,
                                                      input logic [KEY_W-1:0] key);
        return {idx, key};
    endfunction

endpackage

// File: rtl/sort_out_mux.sv
// 32:1 read mux over the packed sorter outputs {s32,...,s1}; s1 sits in the
// lowest ENTRY_W bits and is selected by sel = 0.
module sort_out_mux
    import sort_pkg::*;
#(
    parameter int N_SEL = 32,
    parameter int W     = 29,
    parameter int SEL_W = 5
) (
    input  logic [N_SEL*W-1:0] flat,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       data
);

    // Pure combinational slice select on the registered pointer.
    always_comb begin
        data = flat[int'(sel)*W +: W];
    end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequencing controller for the 32-entry sorting register array: loads a
// frame of tagged keys into the sorter, waits for it to settle, then streams
// the sorted entries downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and while valid is high with
// ready low the payload is held stable.
module sort_seq_ctrl
    import sort_pkg::*;
#(
    parameter int N_ENTRIES  = 32,
    parameter int KEY_W      = 24,
    parameter int SETTLE_CYC = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          in_valid,
    input  logic [KEY_W-1:0]              in_key,
    output logic                          in_ready,
    output logic [IDX_W-1:0]              sr_old_index,
    output logic [ENTRY_W-1:0]            sr_Q,
    output logic                          sr_load,
    output logic                          sr_clear,
    input  logic [N_ENTRIES*ENTRY_W-1:0]  sr_s_flat,
    output logic                          out_valid,
    output logic [ENTRY_W-1:0]            out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic [5:0]                    load_count,
    output logic [1:0]                    dbg_state
);

    localparam logic [5:0]       LAST_LOAD   = 6'(N_ENTRIES - 1);
    localparam logic [IDX_W-1:0] LAST_PTR    = IDX_W'(N_ENTRIES - 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC - 1);

    sort_state_t      state_q;
    sort_state_t      state_d;
    logic [IDX_W-1:0] rd_ptr;
    logic [3:0]       settle_cnt;
    logic             accept;
    logic             out_hs;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks any handshake in the same cycle,
    // while in IDLE only start is looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (abort)                                 state_d = IDLE;
                else if (accept && load_count == LAST_LOAD) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort)                 state_d = IDLE;
                else if (settle_cnt == '0) state_d = OUT;
            end
            OUT: begin
                if (abort)                  state_d = IDLE;
                else if (out_hs && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and handshake qualifiers.
    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUT);
        accept    = in_ready && in_valid;
        out_hs    = out_valid && out_ready;
        out_last  = out_valid && (rd_ptr == LAST_PTR);
        dbg_state = state_q;
    end

    // Counters, sorter strobes and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_Q         <= '0;
            sr_old_index <= '0;
            sr_load      <= 1'b0;
            sr_clear     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            load_count   <= '0;
            rd_ptr       <= '0;
            settle_cnt   <= '0;
        end else begin
            sr_load  <= 1'b0;
            sr_clear <= 1'b0;
            done     <= 1'b0;
            busy     <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_clear   <= 1'b1;
                        load_count <= '0;
                        rd_ptr     <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        sr_clear <= 1'b1;
                    end else if (accept) begin
                        sr_Q         <= make_entry(load_count[IDX_W-1:0], in_key);
                        sr_old_index <= load_count[IDX_W-1:0];
                        sr_load      <= 1'b1;
                        load_count   <= load_count + 6'd1;
                        if (load_count == LAST_LOAD) settle_cnt <= SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        sr_clear <= 1'b1;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (abort) begin
                        sr_clear <= 1'b1;
                    end else if (out_hs) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (out_last) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sort_out_mux #(
        .N_SEL (N_ENTRIES),
        .W     (ENTRY_W),
        .SEL_W (IDX_W)
    ) u_out_mux (
        .flat (sr_s_flat),
        .sel  (rd_ptr),
        .data (out_data)
    );

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl: the sorter array is stood in for by
// a per-frame random set of entries, and expected sorter inserts are kept in
// a queue filled from the accepted keys.
module tb_sort_seq_ctrl;
  import sort_pkg::*;

  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         reset, start, abort, in_valid, out_ready;
  logic [23:0]  in_key;
  logic         in_ready, sr_load, sr_clear, out_valid, out_last, busy, done;
  logic [4:0]   sr_old_index;
  logic [28:0]  sr_Q, out_data;
  logic [927:0] sr_s_flat;
  logic [5:0]   load_count;
  logic [1:0]   dbg_state;

  logic [28:0]  s_ent[32];
  logic [28:0]  exp_q[$];
  logic [28:0]  last_q;
  logic [28:0]  mon_e;
  int n_checks, n_errors, done_cnt, exp_done, model_cnt;

  sort_seq_ctrl #(.N_ENTRIES(32), .KEY_W(24), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_key(in_key), .in_ready(in_ready),
    .sr_old_index(sr_old_index), .sr_Q(sr_Q), .sr_load(sr_load),
    .sr_clear(sr_clear), .sr_s_flat(sr_s_flat), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .load_count(load_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / stand-in sorter ----------------
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 32; i++) sr_s_flat[i*29 +: 29] = s_ent[i];
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor (just after each edge) ----------------
  always begin
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (sr_load) begin
      if (exp_q.size() == 0) begin
        check("sr_load_spurious", 32'(sr_load), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sr_Q", 32'(sr_Q), 32'(mon_e));
        check("sr_old_index", 32'(sr_old_index), 32'(mon_e[28:24]));
        last_q = mon_e;
      end
    end else begin
      check("sr_Q_hold", 32'(sr_Q), 32'(last_q));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_key = '0;
    last_q = '0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_frame(input bit with_abort);
    check("busy_before_start", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) s_ent[i] = 29'($urandom);
    start = 1'b1;
    abort = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    model_cnt = 0;
    check("start_sr_clear", 32'(sr_clear), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_load_count", 32'(load_count), 32'd0);
    check("start_done_low", 32'(done), 32'd0);
  endtask

  // mode 0: full rate, key = index; 1: valid every other cycle; 2: random valid
  task automatic load_keys(input int n, input int mode, input bit poke);
    int cyc = 0;
    while (model_cnt < n && cyc < 400) begin
      case (mode)
        0:       begin in_valid = 1'b1; in_key = 24'(model_cnt); end
        1:       begin in_valid = (cyc % 2 == 0); in_key = 24'($urandom); end
        default: begin in_valid = ($urandom_range(0, 3) != 0); in_key = 24'($urandom); end
      endcase
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back({5'(model_cnt), in_key});
        model_cnt++;
      end
      step();
      cyc++;
      check("load_count", 32'(load_count), 32'(model_cnt));
      check("load_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (model_cnt < n) check("load_timeout", 32'(model_cnt), 32'(n));
  endtask

  task automatic wait_first_out(input bit poke);
    int lat = 1;
    check("settle_in_ready", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      lat++;
    end
    start = 1'b0;
    check("first_out_latency", 32'(lat), 32'(SETTLE + 1));
  endtask

  // Drain entries up to stop_at; stalls 5 cycles at entry stall_at.
  task automatic drain(input int stop_at, input int stall_at, input bit rand_ready);
    int i = 0;
    int stall = 0;
    int cyc = 0;
    bit hs;
    while (i < stop_at && cyc < 500) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(s_ent[i]));
      check("out_last", 32'(out_last), 32'(i == 31));
      if (i == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      hs = out_ready;
      step();
      cyc++;
      if (hs) i++;
    end
    out_ready = 1'b0;
    check("drain_count", 32'(i), 32'(stop_at));
    if (stop_at == 32) begin
      exp_done++;
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_out_valid", 32'(out_valid), 32'd0);
      check("done_count", 32'(done_cnt), 32'(exp_done));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0; n_errors = 0; done_cnt = 0; exp_done = 0; model_cnt = 0;
    last_q = '0;
    for (int i = 0; i < 32; i++) s_ent[i] = '0;
    do_reset();

    // reset values
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_sr_load", 32'(sr_load), 32'd0);
    check("rst_sr_clear", 32'(sr_clear), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_sr_Q", 32'(sr_Q), 32'd0);
    check("rst_sr_old_index", 32'(sr_old_index), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // reset in the middle of LOAD after 10 accepts
    start_frame(1'b0);
    load_keys(10, 2, 1'b0);
    reset = 1'b1;
    last_q = '0;
    step();
    reset = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_load_count", 32'(load_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sr_clear", 32'(sr_clear), 32'd0);
    step();
    step();
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // full-rate frame, keys 0..31, then back-to-back start on the done cycle
    start_frame(1'b0);
    load_keys(32, 0, 1'b0);
    check("f1_settle_busy", 32'(busy), 32'd1);
    wait_first_out(1'b0);
    drain(32, -1, 1'b0);
    start_frame(1'b0);

    // in_valid every other cycle, out_ready stalled at entry 8 (rd_ptr 7)
    load_keys(32, 1, 1'b0);
    wait_first_out(1'b0);
    drain(32, 7, 1'b0);

    // random valid/ready with start poked during LOAD and SETTLE
    step();
    start_frame(1'b0);
    load_keys(32, 2, 1'b1);
    check("f3_state_settle", 32'(dbg_state), 32'(SETTLE));
    wait_first_out(1'b1);
    drain(32, -1, 1'b1);

    // start+abort together in IDLE: start wins; abort in OUT at rd_ptr 20
    step();
    start_frame(1'b1);
    load_keys(32, 2, 1'b0);
    wait_first_out(1'b0);
    drain(20, -1, 1'b1);
    check("abort_out_data", 32'(out_data), 32'(s_ent[20]));
    out_ready = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_out_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_clear", 32'(sr_clear), 32'd1);
    check("abort_out_done", 32'(done), 32'd0);
    step();
    check("abort_out_clear_1cyc", 32'(sr_clear), 32'd0);
    check("abort_out_done_cnt", 32'(done_cnt), 32'(exp_done));

    // new start after abort, then abort in LOAD with a key offered
    start_frame(1'b0);
    load_keys(5, 2, 1'b0);
    in_valid = 1'b1;
    in_key = 24'($urandom);
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_load_busy", 32'(busy), 32'd0);
    check("abort_load_clear", 32'(sr_clear), 32'd1);
    check("abort_load_in_ready", 32'(in_ready), 32'd0);
    step();
    check("abort_load_no_insert", 32'(sr_load), 32'd0);
    check("abort_load_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_seq_ctrl.md
# sort_seq_ctrl

Sequencing controller for the 32-entry sorting register array (`sort_reg`) in the image sorting engine.
- Accepts a frame of 32 pixel keys from upstream over a valid/ready handshake.
- Tags each key with its arrival index and feeds it to the sorter, one insert per accepted key.
- Waits a fixed settle time, then streams the 32 sorted entries (s1 first, s32 last) downstream over a second valid/ready handshake.
- Owns frame start, abort and completion signalling for the sorter.

## Interface
Parameters:
- `N_ENTRIES`, 32: entries per frame; fixed by sorter depth and the 5-bit index.
- `KEY_W`, 24: upstream key width, formatted as {cls[1:0], a[5:0], b[7:0], c[7:0]}.
- `SETTLE_CYC`, 2: cycles between the last sorter insert and the first output; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: frame start request, sampled in IDLE only.
- `abort` in 1: synchronous abort, honoured in any non-IDLE state.
- `in_valid` in 1: upstream key valid.
- `in_key` in 24: upstream key.
- `in_ready` out 1: controller accepts a key.
- `sr_old_index` out 5: index presented to the sorter.
- `sr_Q` out 29: entry presented to the sorter.
- `sr_load` out 1: sorter insert strobe.
- `sr_clear` out 1: sorter clear strobe.
- `sr_s_flat` in 928: sorter outputs packed as {s32,…,s1}; s1 occupies bits [28:0].
- `out_valid` out 1: sorted entry valid.
- `out_data` out 29: sorted entry.
- `out_last` out 1: marks the 32nd output entry.
- `out_ready` in 1: downstream accepts an entry.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle frame-complete pulse.
- `load_count` out 6: number of keys accepted in the current frame, 0..32.

## Operation
- States and transitions:
  - IDLE → LOAD when `start`=1.
  - LOAD → SETTLE when the 32nd key is accepted.
  - SETTLE → OUT when the settle counter expires.
  - OUT → IDLE when the last entry is accepted downstream.
  - Any non-IDLE state → IDLE when `abort`=1.
- IDLE & `start`:
  - `sr_clear` is registered high for exactly one cycle.
  - `load_count` and `rd_ptr` are set to 0.
- LOAD:
  - `in_ready`=1.
  - A key is accepted on `in_valid && in_ready`.
  - On the next edge: `sr_Q` = {load_count[4:0], in_key}, `sr_old_index` = load_count[4:0], `sr_load`=1 for that one cycle, and `load_count` increments.
  - No accept → `sr_load`=0; `sr_Q` and `sr_old_index` hold their values.
- The index prefix is the arrival order 0..31 and never wraps within a frame. `load_count` saturates at 32, and LOAD exits on the accept that takes it from 31 to 32.
- SETTLE:
  - A 4-bit counter loads SETTLE_CYC−1 on entry and decrements.
  - The state moves to OUT on the cycle after the counter reads 0.
  - `in_ready`=0.
- OUT:
  - `out_valid`=1.
  - `out_data` = `sr_s_flat`[rd_ptr*29 +: 29], a combinational mux on the registered `rd_ptr`.
  - `out_last` = (rd_ptr==31).
  - On `out_valid && out_ready`, `rd_ptr` increments.
  - When `out_ready`=0, `out_data` and `out_last` are stable.
- Completion: a handshake with `out_last`=1 → IDLE, and `done` pulses 1 cycle on the following cycle.
- Abort:
  - The block goes to IDLE on the next edge and registers `sr_clear` high for 1 cycle.
  - `done` is not asserted.
  - `abort` takes priority over an accept or output handshake in the same cycle; that key or entry is dropped.
- `start` asserted while `busy` is ignored. `start` and `abort` together in IDLE: `start` wins.
- Reset values: state IDLE; `in_ready`, `sr_load`, `sr_clear`, `out_valid`, `out_last`, `done`, `busy` = 0; `sr_Q`, `sr_old_index`, `load_count`, `rd_ptr`, settle counter = 0.
- Reset does not pulse `sr_clear`; the sorter is reset by the same `reset`.

## Timing
- Every output is registered except `out_data`/`out_last` (combinational mux from registered `rd_ptr` plus the sorter input) and `in_ready`/`out_valid` (decoded from registered state).
- Input latency: key accepted at edge k → `sr_load` high during cycle k+1.
- Maximum load throughput: 1 key/cycle, 32 cycles for a full frame.
- First `out_valid`: SETTLE_CYC+1 cycles after the last accept edge.
- Maximum output throughput: 1 entry/cycle.
- Minimum frame time at full rate: 1 + 32 + SETTLE_CYC + 32 cycles, then the `done` cycle.
- Back-to-back frames: `start` may be asserted in the same cycle as `done`.

## Structure
- Shared package `sort_pkg` holds:
  - constants N_ENTRIES=32, IDX_W=5, KEY_W=24, ENTRY_W=29;
  - the state enum {IDLE, LOAD, SETTLE, OUT};
  - field offsets of the entry: idx[28:24], cls[23:22], a[21:16], b[15:8], c[7:0].
- One natural sub-module: `sort_out_mux`, the 32:1 ENTRY_W-bit read mux indexed by `rd_ptr`.
- The remainder is a single FSM with counters.

## Test plan
- Reset mid-LOAD after 10 accepts → next cycle IDLE, `load_count`=0, `busy`=0, `sr_clear`=0, `done` never asserted.
- Full-rate frame with keys 0x000000..0x00001F:
  - the 32 `sr_load` pulses carry `sr_Q` = {i[4:0], 24'(i)};
  - the first `out_valid` comes 3 cycles (SETTLE_CYC=2) after the last accept;
  - 32 outputs equal s1..s32 in order, `out_last` only on the 32nd, then `done` one cycle later.
- `in_valid` toggling every other cycle → accepts happen only on valid cycles, `sr_old_index` increments by 1 per `sr_load`, and `sr_Q`/`sr_old_index` hold in idle cycles.
- `out_ready` low for 5 cycles at `rd_ptr`=7 → `out_data` stays equal to s8, and `rd_ptr` advances only after `out_ready` rises.
- `abort` in OUT with `rd_ptr`=20 and a handshake in the same cycle → IDLE next cycle, one `sr_clear` pulse, no `done`, and a new `start` is accepted.
- `start` pulsed during LOAD and SETTLE → ignored; `load_count` and the state sequence are unaffected.
